// File: rtl/alarm_unit_if.sv
// Alarm unit signal bundle: current time and user controls in, stored alarm
// time, buzzer and FSM state out. The slave modport is the alarm unit side.
interface alarm_unit_if;
    logic [3:0] hours_tens;
    logic [3:0] hours_ones;
    logic [3:0] minutes_tens;
    logic [3:0] minutes_ones;
    logic       alarm_en;
    logic       set_mode;
    logic       inc_hour;
    logic       inc_min;
    logic       stop;
    logic       snooze;
    logic [3:0] al_ht;
    logic [3:0] al_ho;
    logic [3:0] al_mt;
    logic [3:0] al_mo;
    logic       buzz;
    logic [1:0] state;

    modport master (
        output hours_tens, hours_ones, minutes_tens, minutes_ones,
        output alarm_en, set_mode, inc_hour, inc_min, stop, snooze,
        input  al_ht, al_ho, al_mt, al_mo, buzz, state
    );

    modport slave (
        input  hours_tens, hours_ones, minutes_tens, minutes_ones,
        input  alarm_en, set_mode, inc_hour, inc_min, stop, snooze,
        output al_ht, al_ho, al_mt, al_mo, buzz, state
    );
endinterface

// File: rtl/alarm_unit.sv
// Alarm unit: stores an editable BCD alarm time, rings when the current time
// first matches it, supports stop, snooze (counted in minute changes) and a
// ring timeout. Optional macro ALARM_BLINK_EN makes the buzzer blink with a
// BLINK_HALF-cycle half period while ringing; without it buzz is steady.
module alarm_unit #(
    parameter int unsigned     DEFAULT_HOUR = 6,
    parameter longint unsigned RING_CYCLES  = 64'd50_000_000 * 64'd60,
    parameter int unsigned     SNOOZE_MIN   = 5,
    parameter int unsigned     BLINK_HALF   = 25_000_000
) (
    input  logic         clk,
    input  logic         rst,
    alarm_unit_if.slave  bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_RINGING = 2'd2;
    localparam logic [1:0] S_SNOOZE  = 2'd3;

    localparam int unsigned RT_W = (RING_CYCLES > 64'd1) ? $clog2(RING_CYCLES) : 1;
    localparam int unsigned SC_W = $clog2(SNOOZE_MIN + 1);

    localparam logic [RT_W-1:0] RT_LAST = RT_W'(RING_CYCLES - 64'd1);
    localparam logic [3:0]      DEF_HT  = 4'(DEFAULT_HOUR / 10);
    localparam logic [3:0]      DEF_HO  = 4'(DEFAULT_HOUR % 10);

    // Parameter sanity checks at elaboration time
    if (DEFAULT_HOUR > 23) begin : g_bad_hour
        $error("DEFAULT_HOUR must be 0..23");
    end
    if (SNOOZE_MIN < 1 || SNOOZE_MIN > 15) begin : g_bad_snooze
        $error("SNOOZE_MIN must be 1..15");
    end
    if (RING_CYCLES < 64'd1) begin : g_bad_ring
        $error("RING_CYCLES must be >= 1");
    end
    if (BLINK_HALF < 1) begin : g_bad_blink
        $error("BLINK_HALF must be >= 1");
    end

    logic [3:0]      r_al_ht, r_al_ho, r_al_mt, r_al_mo;
    logic [1:0]      r_state;
    logic            r_buzz;
    logic [RT_W-1:0] r_ring_tmr;
    logic [SC_W-1:0] r_snz_cnt;
    logic            r_match_q;
    logic [3:0]      r_min_prev;
    logic            w_match;
    logic            w_trigger;
    logic            w_minute_evt;

`ifdef ALARM_BLINK_EN
    localparam int unsigned      BC_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BC_W-1:0]  BC_LAST = BC_W'(BLINK_HALF - 1);
    logic [BC_W-1:0] r_blink_cnt;
`endif

    assign w_match = (bus.hours_tens   == r_al_ht) && (bus.hours_ones   == r_al_ho) &&
                     (bus.minutes_tens == r_al_mt) && (bus.minutes_ones == r_al_mo);
    assign w_trigger    = w_match & ~r_match_q;
    assign w_minute_evt = (bus.minutes_ones != r_min_prev);

    assign bus.al_ht = r_al_ht;
    assign bus.al_ho = r_al_ho;
    assign bus.al_mt = r_al_mt;
    assign bus.al_mo = r_al_mo;
    assign bus.buzz  = r_buzz;
    assign bus.state = r_state;

    // Edge detection history: previous match and previous minute units digit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_match_q  <= 1'b0;
            r_min_prev <= '0;
        end else begin
            r_match_q  <= w_match;
            r_min_prev <= bus.minutes_ones;
        end
    end

    // Alarm time storage and BCD editing while in set mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_al_ht <= DEF_HT;
            r_al_ho <= DEF_HO;
            r_al_mt <= '0;
            r_al_mo <= '0;
        end else if (bus.set_mode) begin
            if (bus.inc_min) begin
                if (r_al_mo == 4'd9) begin
                    r_al_mo <= '0;
                    r_al_mt <= (r_al_mt == 4'd5) ? '0 : r_al_mt + 4'd1;
                end else begin
                    r_al_mo <= r_al_mo + 4'd1;
                end
            end
            if (bus.inc_hour) begin
                if (r_al_ht == 4'd2 && r_al_ho == 4'd3) begin
                    r_al_ht <= '0;
                    r_al_ho <= '0;
                end else if (r_al_ho == 4'd9) begin
                    r_al_ht <= r_al_ht + 4'd1;
                    r_al_ho <= '0;
                end else begin
                    r_al_ho <= r_al_ho + 4'd1;
                end
            end
        end
    end

    // Alarm FSM with ring timer, snooze counter and registered buzzer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_buzz     <= 1'b0;
            r_ring_tmr <= '0;
            r_snz_cnt  <= '0;
`ifdef ALARM_BLINK_EN
            r_blink_cnt <= '0;
`endif
        end else if (!bus.alarm_en || bus.set_mode) begin
            r_state <= S_IDLE;
            r_buzz  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_ARMED;
                end
                S_ARMED: begin
                    if (w_trigger) begin
                        r_state    <= S_RINGING;
                        r_ring_tmr <= '0;
                        r_buzz     <= 1'b1;
`ifdef ALARM_BLINK_EN
                        r_blink_cnt <= '0;
`endif
                    end
                end
                S_RINGING: begin
                    if (bus.stop) begin
                        r_state <= S_ARMED;
                        r_buzz  <= 1'b0;
                    end else if (bus.snooze) begin
                        r_state   <= S_SNOOZE;
                        r_snz_cnt <= SC_W'(SNOOZE_MIN);
                        r_buzz    <= 1'b0;
                    end else if (r_ring_tmr == RT_LAST) begin
                        r_state <= S_ARMED;
                        r_buzz  <= 1'b0;
                    end else begin
                        r_ring_tmr <= r_ring_tmr + RT_W'(1);
`ifdef ALARM_BLINK_EN
                        if (r_blink_cnt == BC_LAST) begin
                            r_blink_cnt <= '0;
                            r_buzz      <= ~r_buzz;
                        end else begin
                            r_blink_cnt <= r_blink_cnt + BC_W'(1);
                        end
`endif
                    end
                end
                default: begin
                    if (bus.stop) begin
                        r_state <= S_ARMED;
                    end else if (w_minute_evt) begin
                        r_snz_cnt <= r_snz_cnt - SC_W'(1);
                        if (r_snz_cnt == SC_W'(1)) begin
                            r_state    <= S_RINGING;
                            r_ring_tmr <= '0;
                            r_buzz     <= 1'b1;
`ifdef ALARM_BLINK_EN
                            r_blink_cnt <= '0;
`endif
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_unit.sv
// Bench for alarm_unit: directed scenarios followed by randomized traffic,
// all outputs compared every cycle against a behavioural model that keeps
// times as minutes-of-day integers.
module tb_alarm_unit;

    localparam int RC     = 8;
    localparam int SNZ    = 2;
    localparam int BH     = 3;
    localparam int DEF_H  = 6;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_RING  = 2;
    localparam int M_SNZ   = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alarm_unit_if u_if ();

    alarm_unit #(
        .DEFAULT_HOUR (DEF_H),
        .RING_CYCLES  (64'd8),
        .SNOOZE_MIN   (SNZ),
        .BLINK_HALF   (BH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int tb_now;
    int m_alarm;
    int m_state;
    int m_ring;
    int m_snz;
    bit m_match_q;
    int m_prev_mo;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] bcd16(input int mins);
        int h, m;
        h = mins / 60;
        m = mins % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    function automatic bit exp_buzz();
        if (m_state != M_RING) return 1'b0;
`ifdef ALARM_BLINK_EN
        return ((m_ring / BH) % 2) == 0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic void model_reset();
        m_alarm   = DEF_H * 60;
        m_state   = M_IDLE;
        m_ring    = 0;
        m_snz     = 0;
        m_match_q = 1'b0;
        m_prev_mo = 0;
    endfunction

    function automatic void model_step();
        bit match, trig, mev;
        int mo, h, m;
        mo    = (tb_now % 60) % 10;
        match = (tb_now == m_alarm);
        trig  = match && !m_match_q;
        mev   = (mo != m_prev_mo);
        if (!u_if.alarm_en || u_if.set_mode) begin
            m_state = M_IDLE;
        end else begin
            case (m_state)
                M_IDLE:  m_state = M_ARMED;
                M_ARMED: if (trig) begin m_state = M_RING; m_ring = 0; end
                M_RING: begin
                    if (u_if.stop) m_state = M_ARMED;
                    else if (u_if.snooze) begin m_state = M_SNZ; m_snz = SNZ; end
                    else if (m_ring == RC - 1) m_state = M_ARMED;
                    else m_ring++;
                end
                default: begin
                    if (u_if.stop) m_state = M_ARMED;
                    else if (mev) begin
                        m_snz--;
                        if (m_snz == 0) begin m_state = M_RING; m_ring = 0; end
                    end
                end
            endcase
        end
        if (u_if.set_mode) begin
            h = m_alarm / 60;
            m = m_alarm % 60;
            if (u_if.inc_min)  m = (m + 1) % 60;
            if (u_if.inc_hour) h = (h + 1) % 24;
            m_alarm = h * 60 + m;
        end
        m_match_q = match;
        m_prev_mo = mo;
    endfunction

    task automatic drive_time();
        logic [15:0] t;
        t = bcd16(tb_now);
        u_if.hours_tens   = t[15:12];
        u_if.hours_ones   = t[11:8];
        u_if.minutes_tens = t[7:4];
        u_if.minutes_ones = t[3:0];
    endtask

    task automatic check_all();
        check_val("state", 32'(u_if.state), 32'(m_state));
        check_val("buzz", 32'(u_if.buzz), 32'(exp_buzz()));
        check_val("alarm", {16'd0, u_if.al_ht, u_if.al_ho, u_if.al_mt, u_if.al_mo},
                  {16'd0, bcd16(m_alarm)});
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        u_if.stop     = 1'b0;
        u_if.snooze   = 1'b0;
        u_if.inc_hour = 1'b0;
        u_if.inc_min  = 1'b0;
    endtask

    task automatic set_time(input int mins);
        tb_now = mins;
        drive_time();
    endtask

    int buzz_cnt;

    initial begin
        u_if.alarm_en = 1'b0;
        u_if.set_mode = 1'b0;
        u_if.inc_hour = 1'b0;
        u_if.inc_min  = 1'b0;
        u_if.stop     = 1'b0;
        u_if.snooze   = 1'b0;
        set_time(5 * 60 + 58);

        // asynchronous reset before any clock edge
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_all();
        check_val("rst_alarm_0600", {16'd0, u_if.al_ht, u_if.al_ho, u_if.al_mt, u_if.al_mo}, 32'h0600);
        @(negedge clk);
        rst = 1'b0;

        // 05:59 -> 06:00 rings one edge after the match
        u_if.alarm_en = 1'b1;
        step();
        step();
        check_val("armed", 32'(u_if.state), 32'd1);
        set_time(5 * 60 + 59);
        step();
        set_time(6 * 60);
        step();
        check_val("ring_at_0600", 32'(u_if.state), 32'd2);
        check_val("ring_buzz", 32'(u_if.buzz), 32'd1);

        // stop and snooze together: stop wins, no re-ring while time stays
        u_if.stop   = 1'b1;
        u_if.snooze = 1'b1;
        step();
        check_val("stop_wins", 32'(u_if.state), 32'd1);
        check_val("stop_buzz", 32'(u_if.buzz), 32'd0);
        for (int i = 0; i < 5; i++) step();
        check_val("no_rering", 32'(u_if.state), 32'd1);

        // snooze for two minute changes, then stop during a second snooze
        set_time(6 * 60 + 1);
        step();
        set_time(6 * 60);
        step();
        u_if.snooze = 1'b1;
        step();
        check_val("snoozing", 32'(u_if.state), 32'd3);
        set_time(6 * 60 + 1);
        step();
        step();
        check_val("snooze_one_left", 32'(u_if.state), 32'd3);
        set_time(6 * 60 + 2);
        step();
        check_val("snooze_rering", 32'(u_if.state), 32'd2);
        u_if.snooze = 1'b1;
        step();
        set_time(6 * 60 + 3);
        step();
        u_if.stop = 1'b1;
        step();
        check_val("snooze_stop", 32'(u_if.state), 32'd1);

        // ring timeout with no buttons
        set_time(6 * 60);
        step();
        buzz_cnt = int'(u_if.buzz);
        for (int i = 0; i < 11; i++) begin
            step();
            buzz_cnt += int'(u_if.buzz);
        end
`ifdef ALARM_BLINK_EN
        check_val("buzz_high_cycles", 32'(buzz_cnt), 32'd5);
`else
        check_val("buzz_high_cycles", 32'(buzz_cnt), 32'd8);
`endif
        check_val("timeout_armed", 32'(u_if.state), 32'd1);

        // alarm_en dropped mid-ring
        set_time(6 * 60 + 1);
        step();
        set_time(6 * 60);
        step();
        step();
        step();
        u_if.alarm_en = 1'b0;
        step();
        check_val("en_drop_idle", 32'(u_if.state), 32'd0);
        check_val("en_drop_buzz", 32'(u_if.buzz), 32'd0);
        u_if.alarm_en = 1'b1;
        step();
        step();

        // asynchronous reset mid-ring
        set_time(6 * 60 + 1);
        step();
        set_time(6 * 60);
        step();
        step();
        check_val("pre_rst_ring", 32'(u_if.state), 32'd2);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_val("async_rst_buzz", 32'(u_if.buzz), 32'd0);
        check_all();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();

        // edit alarm to 23:59, then wrap minutes and hours
        u_if.set_mode = 1'b1;
        for (int i = 0; i < 59; i++) begin
            u_if.inc_min  = 1'b1;
            u_if.inc_hour = (i < 17);
            step();
        end
        check_val("edit_2359", {16'd0, u_if.al_ht, u_if.al_ho, u_if.al_mt, u_if.al_mo}, 32'h2359);
        u_if.inc_min = 1'b1;
        step();
        check_val("min_wrap", {16'd0, u_if.al_ht, u_if.al_ho, u_if.al_mt, u_if.al_mo}, 32'h2300);
        u_if.inc_hour = 1'b1;
        step();
        check_val("hour_wrap", {16'd0, u_if.al_ht, u_if.al_ho, u_if.al_mt, u_if.al_mo}, 32'h0000);

        // alarm equals current time while editing: no ring on leaving set mode
        set_time(0);
        step();
        u_if.set_mode = 1'b0;
        u_if.inc_min  = 1'b1;
        u_if.inc_hour = 1'b1;
        step();
        check_val("inc_ignored", {16'd0, u_if.al_ht, u_if.al_ho, u_if.al_mt, u_if.al_mo}, 32'h0000);
        for (int i = 0; i < 4; i++) step();
        check_val("edit_no_ring", 32'(u_if.state), 32'd1);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            u_if.alarm_en = ($urandom_range(0, 99) < 97);
            u_if.set_mode = ($urandom_range(0, 99) < 4);
            u_if.inc_hour = ($urandom_range(0, 3) == 0);
            u_if.inc_min  = ($urandom_range(0, 3) == 0);
            u_if.stop     = ($urandom_range(0, 99) < 3);
            u_if.snooze   = ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 99) < 12) tb_now = (tb_now + 1) % 1440;
            if (m_state == M_ARMED && $urandom_range(0, 99) < 4) tb_now = (m_alarm + 1439) % 1440;
            drive_time();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alarm_unit.md
ALARM_UNIT -- requirements
Module: alarm_unit

Interface
REQ-001 Parameter DEFAULT_HOUR, 6, alarm hour (binary 0-23) loaded at reset.
REQ-002 Parameter RING_CYCLES, 50_000_000*60, clk cycles before RINGING auto-stops.
REQ-003 Parameter SNOOZE_MIN, 5, minute events spent in SNOOZE before re-ringing (1-15).
REQ-004 Parameter BLINK_HALF, 25_000_000, clk cycles per buzz half-period (used only with ALARM_BLINK_EN).
REQ-005 clk  in  1  system clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 hours_tens, hours_ones, minutes_tens, minutes_ones  in  4 each  current BCD time from the 24-hour counter stage.
REQ-008 alarm_en  in  1  level, alarm function enabled.
REQ-009 set_mode  in  1  level, alarm-time edit mode.
REQ-010 inc_hour, inc_min  in  1 each  single-cycle debounced pulses, edit alarm time.
REQ-011 stop, snooze  in  1 each  single-cycle debounced pulses.
REQ-012 al_ht, al_ho, al_mt, al_mo  out  4 each  stored alarm time, BCD, registered.
REQ-013 buzz  out  1  registered buzzer drive.
REQ-014 state  out  2  FSM state: IDLE=0, ARMED=1, RINGING=2, SNOOZE=3.

Function
REQ-015 match SHALL be 1 when all four time digits equal al_ht/al_ho/al_mt/al_mo; match_q SHALL register match each cycle; trigger = match & ~match_q.
REQ-016 minute_evt SHALL be 1 in any cycle where minutes_ones differs from its value registered the previous cycle.
REQ-017 Priority per cycle: alarm_en=0 or set_mode=1 -> IDLE, over all other transitions.
REQ-018 IDLE -> ARMED when alarm_en=1 and set_mode=0.
REQ-019 ARMED -> RINGING on trigger; ring timer cleared to 0.
REQ-020 RINGING: stop -> ARMED; else snooze -> SNOOZE, snooze counter loaded SNOOZE_MIN; else ring timer = RING_CYCLES-1 -> ARMED; else timer +1. stop and snooze together: stop wins.
REQ-021 SNOOZE: stop -> ARMED; else minute_evt decrements counter; decrement reaching 0 -> RINGING with ring timer cleared.
REQ-022 buzz SHALL be 0 in every state except RINGING; it SHALL become 1 at the same clock edge state enters RINGING.
REQ-023 set_mode=1: inc_min increments alarm minutes 00..59, 59 wraps to 00 without touching hours; inc_hour increments hours 00..23, 23 wraps to 00; both in same cycle apply both.
REQ-024 inc_hour/inc_min SHALL be ignored when set_mode=0.
REQ-025 Alarm set equal to current time while edited SHALL NOT ring on leaving set_mode (no trigger edge); next ring occurs at next rising match.
REQ-026 Ring timer and snooze counter widths SHALL hold RING_CYCLES-1 and SNOOZE_MIN without overflow.

Reset
REQ-027 rst=1 SHALL asynchronously set state=IDLE, buzz=0, ring timer=0, snooze counter=0, match_q=0, previous-minute register=0, blink phase=0.
REQ-028 rst=1 SHALL load alarm time DEFAULT_HOUR:00 in BCD (default 06:00).
REQ-029 First cycle after rst release SHALL behave as normal operation with no pending trigger.

Configuration
REQ-030 Macro ALARM_BLINK_EN defined: in RINGING buzz SHALL toggle every BLINK_HALF cycles, starting at 1 on RINGING entry; phase counter cleared on RINGING entry.
REQ-031 ALARM_BLINK_EN undefined: buzz SHALL be steady 1 throughout RINGING; no phase counter built.

Verification
REQ-032 Reset, alarm_en=1, time 05:59 -> 06:00 -> state ARMED then RINGING, buzz=1 one edge after time reaches 06:00.
REQ-033 RINGING, stop and snooze same cycle -> state ARMED, buzz=0 next edge; time stays 06:00 -> no re-ring.
REQ-034 RINGING, snooze, SNOOZE_MIN=2, two minutes_ones changes -> RINGING after second change; stop in between -> ARMED.
REQ-035 set_mode=1, alarm 23:59, one inc_min -> 23:00; one inc_hour -> 00:00; inc pulses with set_mode=0 -> unchanged.
REQ-036 RING_CYCLES=8, no buttons -> buzz high exactly 8 cycles, then ARMED; alarm_en dropped mid-ring -> IDLE, buzz=0 next edge.
REQ-037 ALARM_BLINK_EN, BLINK_HALF=3 -> buzz pattern 1,1,1,0,0,0,1 from RINGING entry; rst mid-ring -> buzz=0 immediately.
